// File: rtl/aria_pkg.sv
// Shared ARIA definitions: mode codes, round count helper and key-store FSM states.
package aria_pkg;

  localparam logic [1:0] ARIA_128 = 2'b00;
  localparam logic [1:0] ARIA_192 = 2'b01;
  localparam logic [1:0] ARIA_256 = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_SERVE
  } rks_state_e;

  // Number of rounds N for a mode; mode 2'b11 behaves as ARIA-256.
  function automatic logic [4:0] aria_nround(input logic [1:0] mode);
    case (mode)
      ARIA_128: return 5'd12;
      ARIA_192: return 5'd14;
      default:  return 5'd16;
    endcase
  endfunction

endpackage

// File: rtl/aria_diff_a.sv
// ARIA diffusion layer A: 16x16 binary involution over bytes, byte x0 = bits [127:120].
module aria_diff_a (
  input  logic [127:0] x_i,
  output logic [127:0] y_o
);

  logic [7:0] x [16];
  logic [7:0] y [16];

  // Unpack bytes, apply the fixed XOR network, repack.
  always_comb begin
    for (int k = 0; k < 16; k++) x[k] = x_i[127-8*k -: 8];
    y[0]  = x[3] ^ x[4] ^ x[6] ^ x[8]  ^ x[9]  ^ x[13] ^ x[14];
    y[1]  = x[2] ^ x[5] ^ x[7] ^ x[8]  ^ x[9]  ^ x[12] ^ x[15];
    y[2]  = x[1] ^ x[4] ^ x[6] ^ x[10] ^ x[11] ^ x[12] ^ x[15];
    y[3]  = x[0] ^ x[5] ^ x[7] ^ x[10] ^ x[11] ^ x[13] ^ x[14];
    y[4]  = x[0] ^ x[2] ^ x[5] ^ x[8]  ^ x[11] ^ x[14] ^ x[15];
    y[5]  = x[1] ^ x[3] ^ x[4] ^ x[9]  ^ x[10] ^ x[14] ^ x[15];
    y[6]  = x[0] ^ x[2] ^ x[7] ^ x[9]  ^ x[10] ^ x[12] ^ x[13];
    y[7]  = x[1] ^ x[3] ^ x[6] ^ x[8]  ^ x[11] ^ x[12] ^ x[13];
    y[8]  = x[0] ^ x[1] ^ x[4] ^ x[7]  ^ x[10] ^ x[13] ^ x[15];
    y[9]  = x[0] ^ x[1] ^ x[5] ^ x[6]  ^ x[11] ^ x[12] ^ x[14];
    y[10] = x[2] ^ x[3] ^ x[5] ^ x[6]  ^ x[8]  ^ x[13] ^ x[15];
    y[11] = x[2] ^ x[3] ^ x[4] ^ x[7]  ^ x[9]  ^ x[12] ^ x[14];
    y[12] = x[1] ^ x[2] ^ x[6] ^ x[7]  ^ x[9]  ^ x[11] ^ x[12];
    y[13] = x[0] ^ x[3] ^ x[6] ^ x[7]  ^ x[8]  ^ x[10] ^ x[13];
    y[14] = x[0] ^ x[3] ^ x[4] ^ x[5]  ^ x[9]  ^ x[11] ^ x[14];
    y[15] = x[1] ^ x[2] ^ x[4] ^ x[5]  ^ x[8]  ^ x[10] ^ x[15];
    y_o = '0;
    for (int k = 0; k < 16; k++) y_o[127-8*k -: 8] = y[k];
  end

endmodule

// File: rtl/aria_rkey_store.sv
// Round-key store: captures encryption round keys, streams them in enc or dec order.
module aria_rkey_store
  import aria_pkg::*;
#(
  parameter int NKEY_MAX = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   aria_mode,
  input  logic         wr_en,
  input  logic [4:0]   wr_addr,
  input  logic [127:0] wr_data,
  input  logic         start,
  input  logic         dec,
  input  logic         rk_req,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic         rk_last,
  output logic         loaded,
  output logic         busy
);

  localparam logic [4:0] MAX_ADDR = 5'(NKEY_MAX - 1);

  rks_state_e   state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [4:0]   n_q, n_d;
  logic         dec_q, dec_d;
  logic         loaded_q, loaded_d;
  logic [1:0]   mode_q, mode_d;
  logic [127:0] rk_out_q, rk_out_d;
  logic         rk_valid_q, rk_valid_d;
  logic         rk_last_q, rk_last_d;

  logic [127:0] key_q [NKEY_MAX];
  logic [4:0]   n_cur;
  logic         idle, wr_ok;
  logic [4:0]   src_idx;
  logic         use_a;
  logic [127:0] raw_key, raw_key_a, sel_key;

  assign n_cur = aria_nround(aria_mode);
  assign idle  = (state_q == S_IDLE);
  assign wr_ok = idle && wr_en && (wr_addr <= n_cur) && (wr_addr <= MAX_ADDR);

  // Key array write port; contents survive reset and mode changes.
  always_ff @(posedge clk) begin
    if (wr_ok) key_q[wr_addr] <= wr_data;
  end

  // Read index: decryption reverses order and diffuses every key except the two end keys.
  always_comb begin
    src_idx = idx_q;
    use_a   = 1'b0;
    if (dec_q) begin
      if (idx_q == 5'd0) begin
        src_idx = n_q;
      end else if (idx_q == n_q) begin
        src_idx = 5'd0;
      end else begin
        src_idx = n_q - idx_q;
        use_a   = 1'b1;
      end
    end
  end

  assign raw_key = key_q[src_idx];

  aria_diff_a u_diff_a (
    .x_i (raw_key),
    .y_o (raw_key_a)
  );

  assign sel_key = use_a ? raw_key_a : raw_key;

  // FSM next state, load tracking and output register updates.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    dec_d      = dec_q;
    loaded_d   = loaded_q;
    mode_d     = mode_q;
    rk_out_d   = rk_out_q;
    rk_valid_d = 1'b0;
    rk_last_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        mode_d = aria_mode;
        if (aria_mode != mode_q) loaded_d = 1'b0;
        // A write of the final key in the same cycle as a mode change wins.
        if (wr_ok && (wr_addr == n_cur)) loaded_d = 1'b1;
        if (start && loaded_q) begin
          state_d = S_SERVE;
          idx_d   = 5'd0;
          n_d     = n_cur;
          dec_d   = dec;
        end
      end
      S_SERVE: begin
        if (rk_req) begin
          rk_out_d   = sel_key;
          rk_valid_d = 1'b1;
          idx_d      = idx_q + 5'd1;
          if (idx_q == n_q) begin
            rk_last_d = 1'b1;
            state_d   = S_IDLE;
            idx_d     = 5'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      dec_q      <= 1'b0;
      loaded_q   <= 1'b0;
      mode_q     <= '0;
      rk_out_q   <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      dec_q      <= dec_d;
      loaded_q   <= loaded_d;
      mode_q     <= mode_d;
      rk_out_q   <= rk_out_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

  assign rk_out   = rk_out_q;
  assign rk_valid = rk_valid_q;
  assign rk_last  = rk_last_q;
  assign loaded   = loaded_q;
  assign busy     = (state_q == S_SERVE);

endmodule

// File: tb/tb_aria_rkey_store.sv
// Randomized self-checking bench for aria_rkey_store against a key-list reference model.
module tb_aria_rkey_store;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   aria_mode = 2'b00;
  logic         wr_en = 1'b0;
  logic [4:0]   wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         start = 1'b0;
  logic         dec = 1'b0;
  logic         rk_req = 1'b0;
  logic [127:0] rk_out;
  logic         rk_valid, rk_last, loaded, busy;

  aria_rkey_store #(.NKEY_MAX(17)) dut (
    .clk(clk), .rst_n(rst_n), .aria_mode(aria_mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .dec(dec), .rk_req(rk_req),
    .rk_out(rk_out), .rk_valid(rk_valid), .rk_last(rk_last),
    .loaded(loaded), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  logic [127:0] ek_m [17];
  bit           m_loaded = 1'b0;
  logic [1:0]   m_mode = 2'b00;
  logic [127:0] obs_q [$];

  // Byte indices feeding each output byte of diffusion layer A.
  int rows [16][7] = '{
    '{3,4,6,8,9,13,14},  '{2,5,7,8,9,12,15},  '{1,4,6,10,11,12,15}, '{0,5,7,10,11,13,14},
    '{0,2,5,8,11,14,15}, '{1,3,4,9,10,14,15}, '{0,2,7,9,10,12,13},  '{1,3,6,8,11,12,13},
    '{0,1,4,7,10,13,15}, '{0,1,5,6,11,12,14}, '{2,3,5,6,8,13,15},   '{2,3,4,7,9,12,14},
    '{1,2,6,7,9,11,12},  '{0,3,6,7,8,10,13},  '{0,3,4,5,9,11,14},   '{1,2,4,5,8,10,15}
  };

  function automatic logic [127:0] amul(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int r = 0; r < 16; r++)
      for (int t = 0; t < 7; t++)
        y[127-8*r -: 8] = y[127-8*r -: 8] ^ x[127-8*rows[r][t] -: 8];
    return y;
  endfunction

  function automatic int nr(input logic [1:0] m);
    return (m == 2'b00) ? 12 : (m == 2'b01) ? 14 : 16;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    aria_mode = m;
    if (m != m_mode) m_loaded = 1'b0;
    m_mode = m;
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [127:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a <= nr(m_mode)) begin
      ek_m[a] = d;
      if (a == nr(m_mode)) m_loaded = 1'b1;
    end
  endtask

  task automatic load_rand();
    for (int a = 0; a <= nr(m_mode); a++) wr(a, rnd128());
  endtask

  // Runs one stream against the model; rst_at >= 0 aborts with a reset before that key.
  task automatic run_stream(input bit d, input bit gap, input int wr_mid_at,
                            input int rst_at, input bit start_on_last);
    int n;
    logic [127:0] exp [$];
    n = nr(m_mode);
    for (int i = 0; i <= n; i++) begin
      if (!d)          exp.push_back(ek_m[i]);
      else if (i == 0) exp.push_back(ek_m[n]);
      else if (i == n) exp.push_back(ek_m[0]);
      else             exp.push_back(amul(ek_m[n-i]));
    end
    obs_q.delete();
    @(negedge clk);
    start = 1'b1; dec = d;
    @(negedge clk);
    start = 1'b0; dec = 1'($urandom);
    chk("busy_on", busy, 1);
    for (int k = 0; k <= n; k++) begin
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out", rk_out, 0);
        chk("rst_valid", rk_valid, 0);
        chk("rst_last", rk_last, 0);
        chk("rst_loaded", loaded, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_loaded = 1'b0;
        return;
      end
      rk_req = 1'b1;
      if (k == wr_mid_at) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = rnd128();
      end
      if (k == n && start_on_last) start = 1'b1;
      @(negedge clk);
      rk_req = 1'b0; wr_en = 1'b0; start = 1'b0;
      chk($sformatf("valid%0d", k), rk_valid, 1);
      chk($sformatf("key%0d", k), rk_out, exp[k]);
      chk($sformatf("last%0d", k), rk_last, (k == n));
      obs_q.push_back(rk_out);
      if (gap && k < n) begin
        @(negedge clk);
        chk("gap_valid", rk_valid, 0);
        chk("gap_hold", rk_out, exp[k]);
      end
    end
    chk("busy_off", busy, 0);
    if (start_on_last) begin
      @(negedge clk);
      chk("start_on_last_ignored", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", rk_out, 0);
    chk("reset_valid", rk_valid, 0);
    chk("reset_last", rk_last, 0);
    chk("reset_loaded", loaded, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Fill every slot once so later modes see defined contents.
    set_mode(2'b10);
    load_rand();

    // ARIA-128 encryption with the byte-pattern keys.
    set_mode(2'b00);
    for (int k = 0; k < 12; k++) wr(k, {16{8'(k)}});
    chk("loaded_before_n", loaded, 0);
    wr(12, {16{8'd12}});
    chk("loaded_at_n", loaded, 1);
    run_stream(1'b0, 1'b0, -1, -1, 1'b0);
    rk_req = 1'b1;
    @(negedge clk);
    rk_req = 1'b0;
    chk("idle_req", rk_valid, 0);

    // Out-of-range write is dropped; key 13 keeps its earlier value under ARIA-192.
    wr(13, rnd128());
    set_mode(2'b01);
    chk("mode_change_unload", loaded, 0);
    wr(14, rnd128());
    chk("loaded_192", loaded, 1);
    run_stream(1'b0, 1'b1, -1, -1, 1'b0);

    // ARIA-256 decryption with the known diffusion vector.
    set_mode(2'b10);
    for (int k = 0; k < 17; k++)
      wr(k, (k == 16) ? 128'hFF : (k == 1) ? {8'h01, 120'h0} : 128'h0);
    run_stream(1'b1, 1'b0, -1, -1, 1'b1);
    chk("dec_first", obs_q[0], 128'h000000FF);
    chk("dec_a_vec", obs_q[15], 128'h00000001_01000100_01010000_00010100);
    chk("dec_last", obs_q[16], 128'h0);
    // Start in the cycle right after the previous rk_last is accepted.
    run_stream(1'b0, 1'b1, -1, -1, 1'b0);

    // Start before the final key is written is ignored.
    set_mode(2'b00);
    for (int k = 0; k < 12; k++) wr(k, rnd128());
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_unloaded", busy, 0);
    rk_req = 1'b1;
    @(negedge clk);
    rk_req = 1'b0;
    chk("req_unloaded", rk_valid, 0);
    wr(12, rnd128());

    // Writes during SERVE are dropped.
    run_stream(1'b0, 1'b0, 1, -1, 1'b0);
    run_stream(1'b1, 1'b1, 2, -1, 1'b0);

    // Randomized modes, orders and request gaps.
    for (int it = 0; it < 6; it++) begin
      set_mode(2'($urandom_range(0, 3)));
      load_rand();
      run_stream(1'($urandom), 1'($urandom), -1, -1, 1'b0);
    end

    // Reset mid-stream, then start must be ignored until reload.
    set_mode(2'b10);
    load_rand();
    run_stream(1'b0, 1'b0, -1, 5, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_after_rst", busy, 0);
    chk("loaded_after_rst", loaded, m_loaded);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aria_rkey_store.md
# aria_rkey_store

Round-key store and sequencer for the ARIA core. It captures the encryption round keys written by `aria_key_gen` (one 128-bit key per address) into a 17-entry register file. On request it streams them to the round datapath one per request, in encryption order or in decryption order. In decryption order the middle keys pass through diffusion layer A.

## Interface
Parameters:
- `NKEY_MAX`, default 17: depth of the key array (ARIA-256 needs 16 rounds + 1 keys).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `aria_mode`  in  2  00 = ARIA-128, 01 = ARIA-192, 10 = ARIA-256, 11 = treated as ARIA-256.
- `wr_en`  in  1  round-key write strobe.
- `wr_addr`  in  5  round-key index, 0..NKEY_MAX-1.
- `wr_data`  in  128  encryption round key ek[wr_addr].
- `start`  in  1  one-cycle pulse that begins a key stream.
- `dec`  in  1  sampled on `start`: 0 = encryption order, 1 = decryption order.
- `rk_req`  in  1  next-key request from the round datapath.
- `rk_out`  out  128  current round key, registered.
- `rk_valid`  out  1  `rk_out` is valid this cycle (one-cycle pulse per request).
- `rk_last`  out  1  qualifies `rk_valid` for the final key of the stream.
- `loaded`  out  1  all keys for the current mode have been written.
- `busy`  out  1  a stream is in progress.

## Operation
- N = 12, 14 or 16 for ARIA-128, -192 and -256 respectively; the key count is N+1.
- **Load**
  - `wr_en` writes `wr_data` into `key[wr_addr]` when the FSM is in IDLE.
  - A write to `wr_addr == N` sets `loaded`.
  - Writes with `wr_addr > N` are dropped.
  - Writes while in SERVE are dropped.
- **Mode change:** any change of `aria_mode` observed in IDLE clears `loaded`. The key array is not cleared.
- **FSM states:** IDLE, SERVE.
  - IDLE → SERVE on `start & loaded`. On that edge: `dec` is latched, index i := 0, `busy` := 1.
  - `start` while `!loaded` is ignored.
  - `start` while in SERVE is ignored.
- **SERVE:** each `rk_req` produces one key and then i := i+1.
  - Encryption order: key(i) = ek[i].
  - Decryption order:
    - key(0) = ek[N].
    - key(i) = A(ek[N-i]) for 1 ≤ i ≤ N-1.
    - key(N) = ek[0].
  - When i == N is served, `rk_last` = 1, the FSM returns to IDLE and `busy` = 0 on the same edge.
  - `rk_req` in IDLE is ignored: no `rk_valid`.
- **Diffusion layer A:** the ARIA 16×16 binary involution (RFC 5794 §2.4.3). Byte x0 is bits [127:120]. Row0: y0 = x3^x4^x6^x8^x9^x13^x14. The remaining rows follow the RFC. A is purely combinational.
- **Reset values:** `rk_out` = 0, `rk_valid` = 0, `rk_last` = 0, `loaded` = 0, `busy` = 0, FSM = IDLE, i = 0. The key array has no reset.

## Timing
- Write: the key is stored at the `wr_en` edge. `loaded` rises at the edge that writes address N.
- `start` → `busy` high in the next cycle. The first `rk_req` is accepted in that same cycle.
- Latency: `rk_req` sampled at edge t → `rk_out`/`rk_valid` at edge t, visible in cycle t+1. This is 1-cycle latency.
  - The A layer sits between the array read mux and the `rk_out` register, so no extra latency.
- Back-to-back `rk_req` every cycle is supported. Throughput is 1 key/cycle.
- Gaps in `rk_req` hold `rk_out` stable with `rk_valid` = 0.
- `rk_last` and `busy` fall in the same cycle.
  - A `start` in the cycle immediately after `rk_last` is accepted.
  - A `start` in the same cycle as the last `rk_req` is ignored.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous). A new stream requires a new full load.

## Structure
- Shared package `aria_pkg`:
  - mode localparams `ARIA_128`, `ARIA_192`, `ARIA_256`;
  - function `aria_nround(mode)` returning 12/14/16;
  - FSM state enum.
- Sub-module `aria_diff_a`: combinational 128 → 128 diffusion layer A. It is shared later with the round datapath.
- Top contains the key array, write decode, index counter, FSM and output register.

## Test plan
- **ARIA-128 encryption stream.** Load ek[k] = {16{k[7:0]}} for k = 0..12, pulse `start` with `dec` = 0, assert `rk_req` for 13 consecutive cycles.
  - Expect 13 `rk_valid` pulses carrying 128'h0000…, 128'h0101…, …, 128'h0C0C….
  - Expect `rk_last` only with 128'h0C0C…, then `busy` = 0.
- **ARIA-256 decryption stream.** Load ek[16] = 128'h00000000_00000000_00000000_000000FF, ek[1] = 128'h01000000_00000000_00000000_00000000, all others 0; pulse `start` with `dec` = 1.
  - First key = ek[16] = …00FF.
  - 16th key = A(ek[1]) = 128'h00000001_01000100_01010000_00010100.
  - Last key = ek[0] = 0.
- **Start not honoured.**
  - Pulse `start` before address N is written → `busy` stays 0 and `rk_req` gives no `rk_valid`.
  - Change `aria_mode` after a full load → `loaded` = 0.
- **Gapped requests.** `rk_req` asserted on alternate cycles → `rk_valid` follows each request by 1 cycle and `rk_out` holds its value between pulses.
- **Write during SERVE.** `wr_en` to address 3 with new data mid-stream → the streamed key 3 still carries the old value.
- **Mid-stream reset.** Assert `rst_n` = 0 at key 5 → all outputs are 0 asynchronously; after release, `start` is ignored until reload.
